// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/execute sequencer for the 3-bit CPU.
// Define INSTR_SEQUENCER_STEP_EN to add the single-step input STEP.
module instr_sequencer #(
    parameter int PCW = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    input  logic           RUN,
`ifdef INSTR_SEQUENCER_STEP_EN
    input  logic           STEP,
`endif
    output logic [PCW-1:0] IMEM_ADDR,
    input  logic [7:0]     IMEM_DATA,
    output logic [3:0]     Opcode,
    output logic [3:0]     OPERAND,
    input  logic           ALU_ZF,
    input  logic           ALU_SF,
    input  logic           ALU_CF,
    output logic           ZF,
    output logic           SF,
    output logic           CF,
    input  logic           JMP_SEL,
    input  logic           ST_SEL,
    output logic [PCW-1:0] PC,
    output logic           EXEC,
    output logic           MEM_WE,
    output logic           HALT
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_STORE, S_HALTED
    } state_t;

    state_t         state_q, state_d;
    logic [PCW-1:0] pc_q, pc_d;
    logic [7:0]     ir_q, ir_d;
    logic [2:0]     flags_q, flags_d;
    logic           step_q, step_d;
    logic           step_req;
    logic [PCW-1:0] pc_inc, jmp_tgt;
    state_t         end_state;

`ifdef INSTR_SEQUENCER_STEP_EN
    assign step_req = STEP;
`else
    assign step_req = 1'b0;
`endif

    assign pc_inc  = pc_q + 1'b1;
    assign jmp_tgt = PCW'(ir_q[3:0]);
    // A single-stepped instruction always parks in IDLE, whatever RUN says.
    assign end_state = (RUN && !step_q) ? S_FETCH : S_IDLE;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            flags_q <= '0;
            step_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            flags_q <= flags_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        flags_d = flags_q;
        step_d  = step_q;
        case (state_q)
            S_IDLE: begin
                if (RUN || step_req) begin
                    state_d = S_FETCH;
                    step_d  = !RUN;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = IMEM_DATA;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (ir_q[7:4] == 4'hF) begin
                    state_d = S_HALTED;
                end else begin
                    // Jump-class opcodes keep flags so the jump tests the prior result.
                    if (ir_q[7:6] != 2'b01) flags_d = {ALU_ZF, ALU_SF, ALU_CF};
                    if (ST_SEL) begin
                        state_d = S_STORE;
                    end else begin
                        pc_d    = JMP_SEL ? jmp_tgt : pc_inc;
                        state_d = end_state;
                        step_d  = 1'b0;
                    end
                end
            end
            S_STORE: begin
                pc_d    = pc_inc;
                state_d = end_state;
                step_d  = 1'b0;
            end
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    assign IMEM_ADDR    = pc_q;
    assign PC           = pc_q;
    assign Opcode       = ir_q[7:4];
    assign OPERAND      = ir_q[3:0];
    assign {ZF, SF, CF} = flags_q;
    assign EXEC         = (state_q == S_EXEC);
    assign MEM_WE       = (state_q == S_STORE);
    assign HALT         = (state_q == S_HALTED);
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized bench with an instruction-level reference model.
module tb_instr_sequencer;
    logic       CLK = 1'b0, RST_N = 1'b1, RUN = 1'b0;
    logic [3:0] IMEM_ADDR, Opcode, OPERAND, PC;
    logic [7:0] IMEM_DATA;
    logic       ALU_ZF = 1'b0, ALU_SF = 1'b0, ALU_CF = 1'b0;
    logic       ZF, SF, CF, EXEC, MEM_WE, HALT;
    logic       JMP_SEL = 1'b0, ST_SEL = 1'b0;
`ifdef INSTR_SEQUENCER_STEP_EN
    logic       STEP = 1'b0;
`endif

    instr_sequencer #(.PCW(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .RUN(RUN),
`ifdef INSTR_SEQUENCER_STEP_EN
        .STEP(STEP),
`endif
        .IMEM_ADDR(IMEM_ADDR), .IMEM_DATA(IMEM_DATA),
        .Opcode(Opcode), .OPERAND(OPERAND),
        .ALU_ZF(ALU_ZF), .ALU_SF(ALU_SF), .ALU_CF(ALU_CF),
        .ZF(ZF), .SF(SF), .CF(CF),
        .JMP_SEL(JMP_SEL), .ST_SEL(ST_SEL),
        .PC(PC), .EXEC(EXEC), .MEM_WE(MEM_WE), .HALT(HALT)
    );

    always #5 CLK = ~CLK;

    logic [7:0] rom [16];
    always @(posedge CLK) IMEM_DATA <= rom[IMEM_ADDR];

    int         vectors = 0, errors = 0;
    logic [3:0] m_pc;
    logic [2:0] m_flags;

    task automatic do_reset;
        @(negedge CLK);
        RST_N = 1'b0;
        RUN   = 1'b0;
        #1;
        vectors++;
        if ({Opcode, OPERAND, PC, IMEM_ADDR, ZF, SF, CF, EXEC, MEM_WE, HALT} !== 22'h0) begin
            errors++;
            $display("FAIL reset_outputs: got op=%h opd=%h pc=%h addr=%h f=%b%b%b ex=%b we=%b h=%b want all 0",
                     Opcode, OPERAND, PC, IMEM_ADDR, ZF, SF, CF, EXEC, MEM_WE, HALT);
        end
        @(negedge CLK);
        RST_N   = 1'b1;
        m_pc    = 4'd0;
        m_flags = 3'd0;
    endtask

    // Starts at a negedge with the DUT in FETCH; runs one instruction against the model.
    task automatic exec_one(input logic jmp, input logic st, input logic drop_run);
        int         n = 0;
        logic [7:0] ins;
        logic [2:0] alu;
        while (EXEC !== 1'b1 && n < 8) begin
            JMP_SEL = 1'($urandom);
            ST_SEL  = 1'($urandom);
            if (drop_run && n == 1) RUN = 1'b0;
            @(negedge CLK);
            n++;
        end
        vectors++;
        if (n != 2) begin
            errors++;
            $display("FAIL exec_latency: EXEC after %0d cycles, want 2", n);
            return;
        end
        ins = rom[m_pc];
        vectors++;
        if ({Opcode, OPERAND, PC, IMEM_ADDR, MEM_WE} !== {ins, m_pc, m_pc, 1'b0}) begin
            errors++;
            $display("FAIL exec_view: got op=%h opd=%h pc=%h addr=%h we=%b want op=%h opd=%h pc=%h we=0",
                     Opcode, OPERAND, PC, IMEM_ADDR, MEM_WE, ins[7:4], ins[3:0], m_pc);
        end
        alu = 3'($urandom);
        {ALU_ZF, ALU_SF, ALU_CF} = alu;
        JMP_SEL = jmp;
        ST_SEL  = st;
        @(negedge CLK);
        {ALU_ZF, ALU_SF, ALU_CF} = 3'($urandom);
        JMP_SEL = 1'($urandom);
        ST_SEL  = 1'($urandom);
        if (ins[7:4] == 4'hF) begin
            vectors++;
            if ({HALT, EXEC, MEM_WE, PC, ZF, SF, CF} !== {3'b100, m_pc, m_flags}) begin
                errors++;
                $display("FAIL halt_entry: got h=%b ex=%b we=%b pc=%h f=%b%b%b want h=1 pc=%h f=%b",
                         HALT, EXEC, MEM_WE, PC, ZF, SF, CF, m_pc, m_flags);
            end
            return;
        end
        if (ins[7:6] != 2'b01) m_flags = alu;
        if (st) begin
            vectors++;
            if ({MEM_WE, EXEC, PC} !== {2'b10, m_pc}) begin
                errors++;
                $display("FAIL store_cycle: got we=%b ex=%b pc=%h want we=1 ex=0 pc=%h",
                         MEM_WE, EXEC, PC, m_pc);
            end
            @(negedge CLK);
            m_pc = m_pc + 4'd1;
        end else if (jmp) begin
            m_pc = ins[3:0];
        end else begin
            m_pc = m_pc + 4'd1;
        end
        vectors++;
        if ({PC, ZF, SF, CF, EXEC, MEM_WE, HALT} !== {m_pc, m_flags, 3'b000}) begin
            errors++;
            $display("FAIL retire: got pc=%h f=%b%b%b ex=%b we=%b h=%b want pc=%h f=%b strobes 0",
                     PC, ZF, SF, CF, EXEC, MEM_WE, HALT, m_pc, m_flags);
        end
    endtask

    task automatic check_idle(input string tag);
        repeat (3) begin
            JMP_SEL = 1'($urandom);
            ST_SEL  = 1'($urandom);
            @(negedge CLK);
            vectors++;
            if ({EXEC, MEM_WE, PC} !== {2'b00, m_pc}) begin
                errors++;
                $display("FAIL %s: got ex=%b we=%b pc=%h want idle pc=%h", tag, EXEC, MEM_WE, PC, m_pc);
            end
        end
    endtask

    task automatic start_run;
        RUN = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        do_reset();
        check_idle("reset_idle");
    endtask

    task automatic test_directed;
        rom[0] = 8'h23; rom[1] = 8'h49; rom[9] = 8'h41;
        rom[2] = 8'h85; rom[3] = 8'h5F; rom[15] = 8'h12;
        do_reset();
        start_run();
        exec_one(1'b0, 1'b0, 1'b0);
        exec_one(1'b1, 1'b0, 1'b0);
        exec_one(1'b1, 1'b0, 1'b0);
        exec_one(1'b0, 1'b0, 1'b0);
        exec_one(1'b0, 1'b1, 1'b0);
        exec_one(1'b1, 1'b0, 1'b0);
        exec_one(1'b0, 1'b0, 1'b0);
        vectors++;
        if (IMEM_ADDR !== 4'h0) begin
            errors++;
            $display("FAIL pc_wrap: got addr=%h want 0", IMEM_ADDR);
        end
        exec_one(1'b0, 1'b0, 1'b1);
        check_idle("run_drop_idle");
    endtask

    task automatic test_random;
        logic [7:0] b;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do b = 8'($urandom); while (b[7:4] == 4'hF);
            rom[i] = b;
        end
        start_run();
        for (int i = 0; i < 60; i++) begin
            exec_one(1'($urandom), 1'($urandom_range(0, 3) == 0), (i % 15) == 14);
            if (!RUN) begin
                check_idle("random_idle");
                start_run();
            end
        end
    endtask

    task automatic test_halt;
        rom[m_pc] = 8'hF3;
        exec_one(1'($urandom), 1'($urandom), 1'b0);
        repeat (10) begin
            RUN = 1'($urandom);
            JMP_SEL = 1'($urandom);
            ST_SEL  = 1'($urandom);
            @(negedge CLK);
            vectors++;
            if ({HALT, EXEC, MEM_WE, PC, ZF, SF, CF} !== {3'b100, m_pc, m_flags}) begin
                errors++;
                $display("FAIL halt_sticky: got h=%b ex=%b we=%b pc=%h want h=1 pc=%h",
                         HALT, EXEC, MEM_WE, PC, m_pc);
            end
        end
    endtask

    task automatic test_reset_mid;
        rom[0] = 8'h85;
        do_reset();
        RUN = 1'b1;
        for (int k = 0; k < 8 && EXEC !== 1'b1; k++) @(negedge CLK);
        vectors++;
        if (EXEC !== 1'b1) begin
            errors++;
            $display("FAIL reach_exec: got ex=%b want 1", EXEC);
        end
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({EXEC, PC, Opcode, HALT} !== 10'h0) begin
            errors++;
            $display("FAIL reset_mid_exec: got ex=%b pc=%h op=%h h=%b want 0", EXEC, PC, Opcode, HALT);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 8 && EXEC !== 1'b1; k++) @(negedge CLK);
        ST_SEL = 1'b1;
        @(negedge CLK);
        vectors++;
        if (MEM_WE !== 1'b1) begin
            errors++;
            $display("FAIL reach_store: got we=%b want 1", MEM_WE);
        end
        RST_N = 1'b0;
        #1;
        vectors++;
        if ({MEM_WE, EXEC, PC} !== 6'h0) begin
            errors++;
            $display("FAIL reset_mid_store: got we=%b ex=%b pc=%h want 0", MEM_WE, EXEC, PC);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        RUN   = 1'b0;
        ST_SEL = 1'b0;
    endtask

`ifdef INSTR_SEQUENCER_STEP_EN
    task automatic test_step;
        int pulses = 0;
        rom[0] = 8'h23;
        do_reset();
        STEP = 1'b1;
        @(negedge CLK);
        STEP = 1'b0;
        ST_SEL = 1'b0;
        JMP_SEL = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            if (EXEC === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 1 || PC !== 4'h1) begin
            errors++;
            $display("FAIL single_step: got pulses=%0d pc=%h want pulses=1 pc=1", pulses, PC);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_halt();
        test_reset_mid();
`ifdef INSTR_SEQUENCER_STEP_EN
        test_step();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Multi-cycle instruction fetch/sequencing unit for the 3-bit CPU. It drives the control unit: it fetches 8-bit instruction words from a synchronous program ROM, holds them in an instruction register, and presents `Opcode`/`OPERAND` plus registered ALU flags `ZF`/`SF`/`CF`. It consumes the control unit's `JMP_SEL` and `ST_SEL` decisions to steer the program counter and the store cycle. It also emits `EXEC`/`MEM_WE` strobes that qualify register-file and data-memory writes.

## Interface
- `PCW`, 4, program-counter / ROM address width (jump target = `OPERAND[PCW-1:0]`)
- `CLK`  in  1  clock, all state updates on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `RUN`  in  1  level; 1 = keep executing, 0 = stop at next instruction boundary
- `IMEM_ADDR`  out  PCW  ROM address, combinationally equal to `PC`
- `IMEM_DATA`  in  8  ROM read data, valid the cycle after address is registered by ROM
- `Opcode`  out  4  `IR[7:4]`, to control unit
- `OPERAND`  out  4  `IR[3:0]`, immediate / register fields / jump target
- `ALU_ZF`, `ALU_SF`, `ALU_CF`  in  1 each  raw ALU flags for current instruction
- `ZF`, `SF`, `CF`  out  1 each  registered flags, to control unit
- `JMP_SEL`  in  1  from control unit: take jump
- `ST_SEL`  in  1  from control unit: current instruction is a store
- `PC`  out  PCW  program counter
- `EXEC`  out  1  high in EXEC state; external logic ANDs with `REG_EN`
- `MEM_WE`  out  1  data-memory write strobe, high only in STORE state
- `HALT`  out  1  sticky halted indicator

## Operation
- States: IDLE, FETCH, DECODE, EXEC, STORE, HALTED.
- IDLE: `RUN`=1 -> FETCH; else stay.
- FETCH: ROM samples `IMEM_ADDR`=PC; -> DECODE unconditionally.
- DECODE: `IR` <= `IMEM_DATA`; -> EXEC.
- EXEC (`EXEC`=1):
  - `Opcode`=4'b1111 -> HALTED; PC unchanged; flags unchanged.
  - else `ST_SEL`=1 -> STORE; PC unchanged.
  - else PC <= `JMP_SEL` ? `OPERAND[PCW-1:0]` : PC+1; -> FETCH if `RUN`=1, else IDLE.
  - Flag capture: `ZF/SF/CF` <= `ALU_*` when `Opcode[3:2]`!=2'b01 and not halt. Jump-class opcodes preserve flags so a jump tests the preceding instruction's result.
- STORE (`MEM_WE`=1): PC <= PC+1; -> FETCH if `RUN`=1, else IDLE.
- HALTED: absorbing; `HALT`=1; `RUN` ignored; only `RST_N` exits.
- PC arithmetic modulo 2^PCW: PC=2^PCW-1 increments to 0. Jump target truncated to PCW bits.
- `RUN` sampled only at IDLE and at instruction end (EXEC/STORE exit); deassertion mid-instruction completes that instruction.

## Timing
- Reset (async assert, sync release): state IDLE, PC=0, IR=8'h00 (`Opcode`=0, `OPERAND`=0), `ZF`=`SF`=`CF`=0, `EXEC`=0, `MEM_WE`=0, `HALT`=0, `IMEM_ADDR`=0.
- Reset mid-operation: all of the above take effect immediately; any in-flight `MEM_WE` drops the same instant.
- Latency from `RUN` rising in IDLE: FETCH next cycle, EXEC three cycles after `RUN` sampled.
- CPI: 3 cycles (FETCH, DECODE, EXEC); 4 for stores (+STORE).
- `EXEC` and `MEM_WE` are each exactly one cycle per instruction, never simultaneously high.
- `Opcode`/`OPERAND` are stable from DECODE exit through the end of EXEC/STORE, so the control-unit outputs are settled in EXEC.
- `JMP_SEL`/`ST_SEL` are sampled only in EXEC; ignored otherwise.

## Configuration
- `INSTR_SEQUENCER_STEP_EN` defined: adds input `STEP` (1 bit). In IDLE with `RUN`=0, a `STEP`=1 cycle runs exactly one instruction (FETCH..EXEC[/STORE]) then returns to IDLE regardless of `RUN`. `STEP` is ignored outside IDLE. `RUN`=1 has priority over `STEP`.
- Not defined: no `STEP` port; IDLE exits only on `RUN`.

## Test plan
- Reset, ROM[0]=8'h23, `RUN`=1 -> FETCH cycle 1, DECODE cycle 2, EXEC cycle 3 with `Opcode`=4'h2, `OPERAND`=4'h3; PC=1 after EXEC; flags = `ALU_*` sampled in EXEC.
- ROM[1]=8'h49, flags preset ZF=1: `JMP_SEL`=1 in EXEC -> PC=9, ZF/SF/CF unchanged; repeat with `JMP_SEL`=0 -> PC=2.
- ROM[2]=8'h85, `ST_SEL`=1 in EXEC -> STORE next cycle, `MEM_WE`=1 exactly one cycle, PC=3, next FETCH 4 cycles after previous.
- PC=15, non-jump instruction -> PC=0 and `IMEM_ADDR`=0 on next FETCH. `RUN` dropped during DECODE -> instruction completes, then IDLE with PC advanced.
- ROM[n]=8'hF0 -> HALT=1 from the cycle after EXEC and stays with `RUN` toggling; `RST_N`=0 mid-EXEC -> IDLE, PC=0, `EXEC`=0 asynchronously.
- With `INSTR_SEQUENCER_STEP_EN`, `RUN`=0, one-cycle `STEP`: exactly one instruction executes (one `EXEC` pulse), PC advances by 1, returns to IDLE.
